// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: decode-side request and datapath control strobes of the sequencer
interface alu_op_sequencer_if;
  logic        start;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        busy, done, err;
  logic [15:0] r_out, r_in;
  logic        mdr_out, mdr_in, read, y_in;
  logic        zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in;
  logic [4:0]  op;
  modport master (
    output start, opcode, ra, rb, rc,
    input  busy, done, err, r_out, r_in, mdr_out, mdr_in, read, y_in,
           zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in, op
  );
  modport slave (
    input  start, opcode, ra, rb, rc,
    output busy, done, err, r_out, r_in, mdr_out, mdr_in, read, y_in,
           zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in, op
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: steps one register instruction through the datapath T-steps with registered strobes
module alu_op_sequencer (
  input logic clock,
  input logic clear,
  alu_op_sequencer_if.slave bus
);
  localparam logic [4:0] OP_AND = 5'b00001;
  localparam logic [4:0] OP_OR  = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_LDI = 5'b01000;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  typedef enum logic [2:0] {IDLE, T_Y, T_ALU, T_ZLO, T_ZHI, T_RD, T_MDR, T_ERR} state_t;
  typedef struct packed {
    logic        busy, done, err;
    logic [15:0] r_out, r_in;
    logic        mdr_out, mdr_in, read, y_in;
    logic        zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in;
    logic [4:0]  op;
  } out_t;
  state_t state, ns;
  logic [4:0] opc, n_opc;
  logic [3:0] ra, rb, rc, n_ra, n_rb, n_rc;
  logic acc, alu, wide, ldi;
  out_t q, d;
  // next state plus the strobes of that state, so every output comes straight from a flop
  always_comb begin
    acc   = state == IDLE && bus.start;
    n_opc = acc ? bus.opcode : opc;
    n_ra  = acc ? bus.ra : ra;
    n_rb  = acc ? bus.rb : rb;
    n_rc  = acc ? bus.rc : rc;
    alu   = n_opc == OP_AND || n_opc == OP_OR || n_opc == OP_ADD || n_opc == OP_SUB;
    wide  = n_opc == OP_MUL || n_opc == OP_DIV;
    ldi   = n_opc == OP_LDI;
    ns    = IDLE;
    case (state)
      IDLE:    ns = !acc ? IDLE : (alu || wide) ? T_Y : ldi ? T_RD : T_ERR;
      T_Y:     ns = T_ALU;
      T_ALU:   ns = T_ZLO;
      T_ZLO:   ns = wide ? T_ZHI : IDLE;
      T_RD:    ns = T_MDR;
      default: ns = IDLE;
    endcase
    d           = '0;
    d.busy      = ns != IDLE;
    d.done      = (ns == T_ZLO && !wide) || ns == T_ZHI || ns == T_MDR || ns == T_ERR;
    d.err       = ns == T_ERR;
    d.r_out     = ns == T_Y ? 16'd1 << n_rb : ns == T_ALU ? 16'd1 << n_rc : 16'd0;
    d.r_in      = (ns == T_ZLO && !wide) || ns == T_MDR ? 16'd1 << n_ra : 16'd0;
    d.y_in      = ns == T_Y;
    d.op        = ns == T_ALU ? n_opc : 5'd0;
    d.zlow_in   = ns == T_ALU;
    d.zhigh_in  = ns == T_ALU;
    d.zlow_out  = ns == T_ZLO;
    d.lo_in     = ns == T_ZLO && wide;
    d.zhigh_out = ns == T_ZHI;
    d.hi_in     = ns == T_ZHI;
    d.read      = ns == T_RD;
    d.mdr_in    = ns == T_RD;
    d.mdr_out   = ns == T_MDR;
  end
  // state, latched instruction fields and output flops; clear forces everything idle at once
  always_ff @(posedge clock or negedge clear)
    if (!clear) begin
      state <= IDLE;
      opc   <= '0;
      ra    <= '0;
      rb    <= '0;
      rc    <= '0;
      q     <= '0;
    end else begin
      state <= ns;
      opc   <= n_opc;
      ra    <= n_ra;
      rb    <= n_rb;
      rc    <= n_rc;
      q     <= d;
    end
  assign bus.busy      = q.busy;
  assign bus.done      = q.done;
  assign bus.err       = q.err;
  assign bus.r_out     = q.r_out;
  assign bus.r_in      = q.r_in;
  assign bus.mdr_out   = q.mdr_out;
  assign bus.mdr_in    = q.mdr_in;
  assign bus.read      = q.read;
  assign bus.y_in      = q.y_in;
  assign bus.zlow_in   = q.zlow_in;
  assign bus.zhigh_in  = q.zhigh_in;
  assign bus.zlow_out  = q.zlow_out;
  assign bus.zhigh_out = q.zhigh_out;
  assign bus.lo_in     = q.lo_in;
  assign bus.hi_in     = q.hi_in;
  assign bus.op        = q.op;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table-driven and scoreboard checks of the sequencer against a small datapath model
module tb_alu_op_sequencer;
  typedef struct packed {
    logic        busy, done, err;
    logic [15:0] r_out, r_in;
    logic        y_in;
    logic [4:0]  op;
    logic        zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in, read, mdr_in, mdr_out;
  } step_t;
  typedef struct {
    logic [4:0]  opc;
    logic [3:0]  ra, rb, rc;
    int          len;
    int          dst;
    logic [31:0] val;
  } vec_t;
  logic clock = 0;
  logic clear = 0;
  logic load = 1;
  always #5 clock = ~clock;
  alu_op_sequencer_if bus ();
  alu_op_sequencer dut (.clock(clock), .clear(clear), .bus(bus));
  int errors = 0;
  int checks = 0;
  int rd = 0;
  int base = 0;
  int busy_total = 0;
  step_t exp_q[$];
  vec_t vecs[8];
  logic [31:0] rf[16];
  logic [31:0] y, zlo, zhi, lo, hi, mdr;
  logic [31:0] mdatain = 32'hDEADBEEF;
  function automatic logic [31:0] bus_val();
    logic [31:0] v = 0;
    for (int i = 0; i < 16; i++) if (bus.r_out[i]) v = rf[i];
    if (bus.mdr_out) v = mdr;
    if (bus.zlow_out) v = zlo;
    if (bus.zhigh_out) v = zhi;
    return v;
  endfunction
  // behavioural datapath driven only by the strobes
  always @(posedge clock) begin
    logic [31:0] b;
    b = bus_val();
    if (load) begin
      for (int i = 0; i < 16; i++) rf[i] <= 0;
      rf[0] <= 12; rf[2] <= 5; rf[3] <= 9; rf[4] <= 6; rf[5] <= 7;
      {y, zlo, zhi, lo, hi, mdr} <= '0;
    end else begin
      if (bus.y_in) y <= b;
      if (bus.zlow_in)
        case (bus.op)
          5'd1:    {zhi, zlo} <= {32'd0, y & b};
          5'd2:    {zhi, zlo} <= {32'd0, y | b};
          5'd3:    {zhi, zlo} <= {32'd0, y + b};
          5'd4:    {zhi, zlo} <= {32'd0, y - b};
          5'd15:   {zhi, zlo} <= 64'(y) * 64'(b);
          5'd16:   begin zlo <= y / b; zhi <= y % b; end
          default: ;
        endcase
      for (int i = 0; i < 16; i++) if (bus.r_in[i]) rf[i] <= b;
      if (bus.lo_in) lo <= b;
      if (bus.hi_in) hi <= b;
      if (bus.read && bus.mdr_in) mdr <= mdatain;
    end
  end
  function automatic step_t snap();
    step_t s;
    s.busy = bus.busy; s.done = bus.done; s.err = bus.err;
    s.r_out = bus.r_out; s.r_in = bus.r_in; s.y_in = bus.y_in; s.op = bus.op;
    s.zlo_in = bus.zlow_in; s.zhi_in = bus.zhigh_in; s.zlo_out = bus.zlow_out;
    s.zhi_out = bus.zhigh_out; s.lo_in = bus.lo_in; s.hi_in = bus.hi_in;
    s.read = bus.read; s.mdr_in = bus.mdr_in; s.mdr_out = bus.mdr_out;
    return s;
  endfunction
  function automatic void push_steps(input logic [4:0] o, input logic [3:0] a, b, c);
    step_t s;
    logic w;
    w = o == 5'h0F || o == 5'h10;
    if (o inside {5'h01, 5'h02, 5'h03, 5'h04} || w) begin
      s = '0; s.busy = 1; s.r_out = 16'd1 << b; s.y_in = 1; exp_q.push_back(s);
      s = '0; s.busy = 1; s.r_out = 16'd1 << c; s.op = o; s.zlo_in = 1; s.zhi_in = 1; exp_q.push_back(s);
      s = '0; s.busy = 1; s.zlo_out = 1;
      if (w) s.lo_in = 1;
      else begin s.r_in = 16'd1 << a; s.done = 1; end
      exp_q.push_back(s);
      if (w) begin
        s = '0; s.busy = 1; s.zhi_out = 1; s.hi_in = 1; s.done = 1; exp_q.push_back(s);
      end
    end else if (o == 5'h08) begin
      s = '0; s.busy = 1; s.read = 1; s.mdr_in = 1; exp_q.push_back(s);
      s = '0; s.busy = 1; s.mdr_out = 1; s.r_in = 16'd1 << a; s.done = 1; exp_q.push_back(s);
    end else begin
      s = '0; s.busy = 1; s.err = 1; s.done = 1; exp_q.push_back(s);
    end
  endfunction
  function automatic logic [31:0] get(input int dst);
    return dst < 16 ? rf[dst] : dst == 16 ? lo : hi;
  endfunction
  task automatic check_step(input string n, input step_t act, input step_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endtask
  task automatic check_val(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endtask
  task automatic monitor();
    forever begin
      @(negedge clock);
      if (rd < base) rd = base;
      checks++;
      if ($countones(bus.r_out) + int'(bus.mdr_out) + int'(bus.zlow_out) + int'(bus.zhigh_out) > 1 ||
          !$onehot0(bus.r_out) || !$onehot0(bus.r_in)) begin
        errors++;
        $display("FAIL invariant: r_out=%h r_in=%h mdr_out=%b zlow_out=%b zhigh_out=%b required one driver, one-hot",
                 bus.r_out, bus.r_in, bus.mdr_out, bus.zlow_out, bus.zhigh_out);
      end
      if (bus.busy) busy_total++;
      if (rd < exp_q.size()) begin
        check_step("step", snap(), exp_q[rd]);
        rd++;
      end else if (bus.busy) begin
        checks++;
        errors++;
        $display("FAIL spurious_busy: got busy=1 required 0");
      end
    end
  endtask
  task automatic issue(input logic [4:0] o, input logic [3:0] a, b, c);
    bus.start = 1; bus.opcode = o; bus.ra = a; bus.rb = b; bus.rc = c;
    @(posedge clock);
    push_steps(o, a, b, c);
    #1 bus.start = 0;
  endtask
  task automatic wait_drain();
    for (int k = 0; k < 40 && rd < exp_q.size(); k++) begin
      @(negedge clock);
      #1;
    end
    if (rd < exp_q.size()) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d steps pending required 0", exp_q.size() - rd);
      base = exp_q.size();
    end
  endtask
  initial begin
    int b0;
    vecs[0] = '{5'h02, 4'd1, 4'd0, 4'd2, 3, 1, 32'd13};
    vecs[1] = '{5'h0F, 4'd0, 4'd4, 4'd5, 4, 16, 32'd42};
    vecs[2] = '{5'h08, 4'd7, 4'd0, 4'd0, 2, 7, 32'hDEADBEEF};
    vecs[3] = '{5'h03, 4'd3, 4'd3, 4'd3, 3, 3, 32'd18};
    vecs[4] = '{5'h04, 4'd8, 4'd2, 4'd0, 3, 8, 32'hFFFFFFF9};
    vecs[5] = '{5'h01, 4'd9, 4'd0, 4'd2, 3, 9, 32'd4};
    vecs[6] = '{5'h1F, 4'd6, 4'd1, 4'd2, 1, 6, 32'd0};
    vecs[7] = '{5'h00, 4'd0, 4'd3, 4'd4, 1, 0, 32'd12};
    bus.start = 0; bus.opcode = 0; bus.ra = 0; bus.rb = 0; bus.rc = 0;
    repeat (2) @(posedge clock);
    #1 check_step("reset", snap(), '0);
    @(negedge clock);
    clear = 1;
    load = 0;
    fork monitor(); join_none
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      b0 = busy_total;
      issue(vecs[i].opc, vecs[i].ra, vecs[i].rb, vecs[i].rc);
      wait_drain();
      @(posedge clock);
      #1;
      check_val($sformatf("result%0d", i), get(vecs[i].dst), vecs[i].val);
      check_val($sformatf("busy_len%0d", i), 32'(busy_total - b0), 32'(vecs[i].len));
    end
    check_val("mul_hi", hi, 32'd0);
    @(negedge clock);
    issue(5'h03, 4'd10, 4'd0, 4'd2);
    @(posedge clock);
    #2 clear = 0;
    base = exp_q.size();
    #1 check_step("clear_mid", snap(), '0);
    repeat (2) @(negedge clock);
    clear = 1;
    check_val("abandoned", rf[10], 32'd0);
    @(negedge clock);
    issue(5'h01, 4'd11, 4'd0, 4'd2);
    wait_drain();
    @(posedge clock);
    #1 check_val("after_clear", rf[11], 32'd4);
    @(negedge clock);
    bus.start = 1; bus.opcode = 5'h03; bus.ra = 12; bus.rb = 0; bus.rc = 2;
    @(posedge clock);
    push_steps(5'h03, 4'd12, 4'd0, 4'd2);
    exp_q.push_back('0);
    push_steps(5'h02, 4'd13, 4'd2, 4'd0);
    #1 bus.opcode = 5'h02; bus.ra = 13; bus.rb = 2; bus.rc = 0;
    repeat (7) @(posedge clock);
    #1 bus.start = 0;
    wait_drain();
    @(posedge clock);
    #1 check_val("b2b_first", rf[12], 32'd17);
    check_val("b2b_second", rf[13], 32'd13);
    @(negedge clock);
    issue(5'h10, 4'd0, 4'd5, 4'd4);
    @(negedge clock);
    bus.start = 1; bus.opcode = 5'h03; bus.ra = 14; bus.rb = 0; bus.rc = 2;
    @(posedge clock);
    #1 bus.start = 0;
    wait_drain();
    @(posedge clock);
    #1 check_val("div_lo", lo, 32'd1);
    check_val("div_hi", hi, 32'd1);
    check_val("dropped", rf[14], 32'd0);
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
